branch_predictor: RTL and testbench

Parametrised branch prediction unit for the pipelined RV32 core. It is a direct-mapped branch target buffer combined with saturating-counter direction prediction. The unit sits beside the IF-stage PC register: it predicts taken/target for the fetch PC and is trained by the ID stage, where branches and jumps resolve. With it, the core can redirect fetch early instead of always fetching PC+4 and flushing on every taken branch.

---
 rtl/branch_predictor.sv | 116 +++++++++++
 tb/tb_branch_predictor.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with saturating-counter direction prediction.
//
// Combinational lookup of the fetch PC. Training comes from the ID stage, one
// resolved branch or jump per cycle.
// Optional feature: define BP_PERF_CNT_EN to build the lookup and mispredict counters.
//
// Ports:
//   clk              clock; all state changes on the rising edge
//   rst              asynchronous active-low reset
//   lookup_en        fetch PC advances this cycle (used only for counting)
//   lookup_pc        current fetch PC
//   pred_taken       lookup_pc is predicted taken
//   pred_target      predicted next PC
//   upd_en           a resolved control-flow instruction is in ID
//   upd_pc           PC of that instruction
//   upd_taken        its actual direction
//   upd_target       its actual target
//   upd_mispredict   ID detected a wrong prediction (qualified by upd_en)
//   flush_all        synchronously invalidates every entry
//   perf_lookups     lookup counter (0 when BP_PERF_CNT_EN is undefined)
//   perf_mispredicts mispredict counter (0 when BP_PERF_CNT_EN is undefined)
module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lookup_en,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_en,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_mispredict,
    input  logic              flush_all,
    output logic [31:0]       perf_lookups,
    output logic [31:0]       perf_mispredicts
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] WEAK_T  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] WEAK_N  = WEAK_T - CNT_W'(1);

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem [ENTRIES];
    logic [ADDR_W-1:0]  tgt_mem [ENTRIES];
    logic [CNT_W-1:0]   cnt_mem [ENTRIES];

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic             l_hit, u_hit;
    logic [CNT_W-1:0] u_cnt;

    assign l_idx = lookup_pc[IDX_W+1:2];
    assign l_tag = lookup_pc[ADDR_W-1:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[ADDR_W-1:IDX_W+2];
    assign u_cnt = cnt_mem[u_idx];

    assign l_hit       = valid[l_idx] && (tag_mem[l_idx] == l_tag);
    assign u_hit       = valid[u_idx] && (tag_mem[u_idx] == u_tag);
    assign pred_taken  = l_hit && cnt_mem[l_idx][CNT_W-1];
    assign pred_target = pred_taken ? tgt_mem[l_idx] : lookup_pc + ADDR_W'(4);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) cnt_mem[i] <= WEAK_N;
        end else if (flush_all) begin
            valid <= '0;
        end else if (upd_en) begin
            if (u_hit)
                cnt_mem[u_idx] <= upd_taken ? ((u_cnt == CNT_MAX) ? u_cnt : u_cnt + CNT_W'(1))
                                            : ((u_cnt == '0) ? u_cnt : u_cnt - CNT_W'(1));
            else if (upd_taken) begin
                valid[u_idx]   <= 1'b1;
                cnt_mem[u_idx] <= WEAK_T;
            end
        end
    end

    // Every taken update writes tag and target: on a hit the tag is unchanged,
    // on a miss this is the allocation.
    always_ff @(posedge clk) begin
        if (!flush_all && upd_en && upd_taken) begin
            tag_mem[u_idx] <= u_tag;
            tgt_mem[u_idx] <= upd_target;
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] lookups_q, misp_q;
    logic        unused_ok;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lookups_q <= '0;
            misp_q    <= '0;
        end else begin
            if (lookup_en) lookups_q <= lookups_q + 32'd1;
            if (upd_en && upd_mispredict) misp_q <= misp_q + 32'd1;
        end
    end
    assign perf_lookups     = lookups_q;
    assign perf_mispredicts = misp_q;
    assign unused_ok        = ^upd_pc[1:0];
`else
    logic unused_ok;
    assign perf_lookups     = '0;
    assign perf_mispredicts = '0;
    assign unused_ok        = ^{upd_pc[1:0], lookup_en, upd_mispredict};
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vector bench for branch_predictor.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lookup_en = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_en = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_mispredict = 1'b0;
    logic        flush_all = 1'b0;
    logic [31:0] perf_lookups, perf_mispredicts;

    int checks = 0;
    int failures = 0;

    branch_predictor dut (
        .clk(clk), .rst(rst), .lookup_en(lookup_en), .lookup_pc(lookup_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_mispredict(upd_mispredict), .flush_all(flush_all),
        .perf_lookups(perf_lookups), .perf_mispredicts(perf_mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ue;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        fl;
        logic [31:0] lpc;
        logic        et;
        logic [31:0] etgt;
    } vec_t;

    vec_t vecs[25];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

`ifdef BP_PERF_CNT_EN
    localparam logic [31:0] EXP_LOOKUPS = 32'd10;
    localparam logic [31:0] EXP_MISP    = 32'd2;
`else
    localparam logic [31:0] EXP_LOOKUPS = 32'd0;
    localparam logic [31:0] EXP_MISP    = 32'd0;
`endif

    initial begin
        // Each vector: update inputs and lookup applied together; expected
        // prediction reflects state before this vector's clock edge.
        vecs[0]  = '{1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h100, 1'b0, 32'h104};
        vecs[1]  = '{1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h100, 1'b0, 32'h104};
        vecs[2]  = '{1'b1, 32'h100, 1'b0, 32'h0,  1'b0, 32'h100, 1'b1, 32'h80};
        vecs[3]  = '{1'b1, 32'h100, 1'b0, 32'h0,  1'b0, 32'h100, 1'b0, 32'h104};
        vecs[4]  = '{1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h100, 1'b0, 32'h104};
        vecs[5]  = '{1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h100, 1'b0, 32'h104};
        vecs[6]  = '{1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h100, 1'b1, 32'h80};
        vecs[7]  = '{1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h100, 1'b1, 32'h80};
        vecs[8]  = '{1'b1, 32'h100, 1'b1, 32'h90, 1'b0, 32'h100, 1'b1, 32'h80};
        vecs[9]  = '{1'b1, 32'h100, 1'b0, 32'h0,  1'b0, 32'h100, 1'b1, 32'h90};
        vecs[10] = '{1'b1, 32'h100, 1'b0, 32'h0,  1'b0, 32'h100, 1'b1, 32'h90};
        vecs[11] = '{1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h100, 1'b0, 32'h104};
        vecs[12] = '{1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h200, 1'b0, 32'h204};
        vecs[13] = '{1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h100, 1'b1, 32'h80};
        vecs[14] = '{1'b1, 32'h200, 1'b1, 32'h40, 1'b0, 32'h200, 1'b0, 32'h204};
        vecs[15] = '{1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h100, 1'b0, 32'h104};
        vecs[16] = '{1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h200, 1'b1, 32'h40};
        vecs[17] = '{1'b1, 32'h504, 1'b0, 32'h0,  1'b0, 32'h504, 1'b0, 32'h508};
        vecs[18] = '{1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h504, 1'b0, 32'h508};
        vecs[19] = '{1'b1, 32'h300, 1'b1, 32'h20, 1'b1, 32'h200, 1'b1, 32'h40};
        vecs[20] = '{1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h200, 1'b0, 32'h204};
        vecs[21] = '{1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h300, 1'b0, 32'h304};
        vecs[22] = '{1'b1, 32'h300, 1'b1, 32'h20, 1'b0, 32'h300, 1'b0, 32'h304};
        vecs[23] = '{1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'h300, 1'b1, 32'h20};
        vecs[24] = '{1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0};

        lookup_pc = 32'h100;
        repeat (2) @(posedge clk);
        #1;
        check("reset_taken", {31'b0, pred_taken}, 32'h0);
        check("reset_target", pred_target, 32'h104);
        check("reset_perf_lookups", perf_lookups, 32'h0);
        check("reset_perf_misp", perf_mispredicts, 32'h0);
        #3 rst = 1'b1;
        step();

        for (int i = 0; i < 25; i++) begin
            upd_en = vecs[i].ue;
            upd_pc = vecs[i].upc;
            upd_taken = vecs[i].ut;
            upd_target = vecs[i].utgt;
            flush_all = vecs[i].fl;
            lookup_pc = vecs[i].lpc;
            #1;
            check($sformatf("vec%0d_taken", i), {31'b0, pred_taken}, {31'b0, vecs[i].et});
            check($sformatf("vec%0d_target", i), pred_target, vecs[i].etgt);
            step();
        end
        upd_en = 1'b0;
        flush_all = 1'b0;

        // Asynchronous reset mid-cycle clears a valid entry immediately.
        lookup_pc = 32'h300;
        #1;
        check("pre_rst_taken", {31'b0, pred_taken}, 32'h1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_taken", {31'b0, pred_taken}, 32'h0);
        check("async_rst_target", pred_target, 32'h304);
        step();
        #2 rst = 1'b1;
        step();

        // Perf counters: 10 lookup cycles, 3 mispredict pulses, one without upd_en.
        for (int i = 0; i < 10; i++) begin
            lookup_en = 1'b1;
            upd_mispredict = (i == 2 || i == 5 || i == 7);
            upd_en = (i == 2 || i == 5);
            upd_pc = 32'h700;
            upd_taken = 1'b0;
            step();
        end
        lookup_en = 1'b0;
        upd_en = 1'b0;
        upd_mispredict = 1'b0;
        step();
        check("perf_lookups", perf_lookups, EXP_LOOKUPS);
        check("perf_mispredicts", perf_mispredicts, EXP_MISP);
        lookup_pc = 32'h700;
        #1;
        check("nt_miss_no_alloc", {31'b0, pred_taken}, 32'h0);

        lookup_en = 1'b1;
        repeat (3) step();
        #2 rst = 1'b0;
        #1;
        check("rst_perf_lookups", perf_lookups, 32'h0);
        check("rst_perf_misp", perf_mispredicts, 32'h0);
        lookup_en = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
